seq_gen_multi: RTL and testbench
================================

Name: seq_gen_multi

Overview:
Parametrised linear-recurrence sequence generator: each term is the masked sum of the last Depth terms (x[n] = sum of x[n-k] for every k whose mask bit k-1 is set). Covers Fibonacci, Tribonacci, Padovan and similar sequences.
Adds runtime seed/mask load, start/stop control, a term limit, valid/ready output backpressure and sticky overflow detection.
Acts as a stimulus/pattern source feeding downstream datapath blocks.

Parameters:
DataBus, 32, term width in bits
Depth, 4, history length (max recurrence order), >=2
CntW, 16, width of term counter and term limit
ResetMask, 4'b0110, mask after reset (Depth bits; default x[n-2]+x[n-3], Padovan)

Ports:
clk_w  in  1  clock
reset_w  in  1  synchronous active-high reset
cfg_load_i  in  1  load mask/seeds (honoured in IDLE/DONE only)
cfg_mask_i  in  Depth  tap mask; bit k-1 selects x[n-k]
cfg_seed_i  in  Depth*DataBus  seeds; slice k-1 -> hist[k] (hist[1] = most recent)
start_i  in  1  begin/resume generation
stop_i  in  1  stop after the held term drains
max_terms_i  in  CntW  term limit, sampled at start; 0 = unlimited
seq_o_w  out  DataBus  current term
seq_valid_o  out  1  seq_o_w valid
seq_ready_i  in  1  consumer accepts term
term_cnt_o  out  CntW  terms generated since last clear
overflow_o  out  1  sticky: some term exceeded DataBus bits
busy_o  out  1  state is RUN or DRAIN
done_o  out  1  state is DONE

Behaviour:
- Reset values:
  - hist[1]=1; other hist = 0; mask = ResetMask; state = IDLE.
  - seq_o_w = 0; seq_valid_o = 0; term_cnt_o = 0; overflow_o = 0; limit = 0.
- Arithmetic:
  - sum is computed at width DataBus+clog2(Depth) over the selected hist entries.
  - The term is sum mod 2^DataBus.
  - overflow_o is set on the same edge the wrapped term is registered if any upper sum bit is nonzero.
  - mask = 0 yields zero terms.
- Generate step (one edge):
  - seq_o_w <= term; hist shifts (hist[k+1] <= hist[k]; hist[1] <= term).
  - seq_valid_o <= 1; term_cnt_o <= term_cnt_o + 1, wrapping at 2^CntW.
- Output register is free when !seq_valid_o or (seq_valid_o and seq_ready_i).
- While seq_valid_o && !seq_ready_i, seq_o_w is held stable.
- States:
  - IDLE:
    - cfg_load_i: mask/hist <= cfg; term_cnt <= 0; overflow <= 0.
    - start_i: latch max_terms_i; generate step; -> RUN. seq_valid_o rises the cycle after start_i is sampled.
    - start_i and cfg_load_i in the same cycle: load applies first, and the step uses the new seeds.
  - RUN:
    - stop_i: no further steps; -> DRAIN. stop_i beats a step in the same cycle.
    - Else, if the output register is free:
      - Limit reached (limit != 0 and term_cnt == limit): seq_valid_o <= 0; -> DONE.
      - Otherwise: generate step.
    - cfg_load_i and start_i are ignored in RUN.
  - DRAIN:
    - Once the output register is free: seq_valid_o <= 0; -> IDLE.
    - start_i is ignored in DRAIN.
  - DONE:
    - cfg_load_i behaves as in IDLE.
    - start_i: term_cnt <= 0, then generate step (term_cnt = 1); -> RUN. Continues from the current hist.
- Resume from IDLE after stop continues the sequence and keeps term_cnt_o.
- stop_i in IDLE/DONE is ignored; start_i and stop_i together in IDLE means start.
- reset_w mid-operation aborts everything to reset values on the next edge, including a pending held term.
- Throughput is 1 term/cycle with seq_ready_i held high.

Decomposition:
- Package seq_gen_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE).
  - mask presets MASK_FIB=4'b0011, MASK_TRIB=4'b0111, MASK_PADOVAN=4'b0110.
  - function for sum width.
- Sub-module seq_sum_tree: combinational masked adder.
  - Inputs: hist array, mask.
  - Outputs: DataBus-bit term and overflow bit.
- Control FSM and registers stay in seq_gen_multi.

Test Plan:
- Reset defaults, start with max_terms=11, ready=1 -> seq_o_w 0,1,1,1,2,2,3,4,5,7,9 on consecutive cycles. Then done_o=1, seq_valid_o=0, term_cnt_o=11.
- cfg_load mask=0011, seeds hist[1]=1, others 0, start, max=6 -> 1,2,3,5,8,13. term_cnt_o=6.
- DataBus=8, Fibonacci as above, unlimited -> term 12 = 233 with overflow_o=0. Term 13 = 121 with overflow_o=1 and sticky. A subsequent cfg_load clears it.
- Fibonacci with seq_ready_i low for 3 cycles after term 3 -> seq_o_w held at 3, no hist change. Next term 5 appears the cycle after the accept.
- stop_i while term 5 is held unaccepted -> busy until accept, then IDLE with term_cnt_o=4. start_i resumes with 8, term_cnt_o=5.
- reset_w asserted in RUN with a term held -> next cycle all outputs at reset values. Start reproduces the Padovan sequence 0,1,1,1,2.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// ============================================================================
// Module : seq_gen_pkg
// Brief  : Shared state encoding, tap-mask presets and sum-width helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] MASK_FIB     = 4'b0011;
  localparam logic [3:0] MASK_TRIB    = 4'b0111;
  localparam logic [3:0] MASK_PADOVAN = 4'b0110;

  // Wide enough that summing every history entry can never wrap.
  function automatic int sum_width(input int data_w, input int depth);
    return data_w + $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_gen_multi_if.sv
// ============================================================================
// Module : seq_gen_if
// Brief  : Configuration, control and term-output bundle of seq_gen_multi.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface seq_gen_if #(
  parameter int DataBus = 32,
  parameter int Depth   = 4,
  parameter int CntW    = 16
) ();

  logic                       cfg_load_i;
  logic [Depth-1:0]           cfg_mask_i;
  logic [Depth*DataBus-1:0]   cfg_seed_i;
  logic                       start_i;
  logic                       stop_i;
  logic [CntW-1:0]            max_terms_i;
  logic [DataBus-1:0]         seq_o_w;
  logic                       seq_valid_o;
  logic                       seq_ready_i;
  logic [CntW-1:0]            term_cnt_o;
  logic                       overflow_o;
  logic                       busy_o;
  logic                       done_o;

  modport master (
    output cfg_load_i, cfg_mask_i, cfg_seed_i, start_i, stop_i, max_terms_i,
    output seq_ready_i,
    input  seq_o_w, seq_valid_o, term_cnt_o, overflow_o, busy_o, done_o
  );

  modport slave (
    input  cfg_load_i, cfg_mask_i, cfg_seed_i, start_i, stop_i, max_terms_i,
    input  seq_ready_i,
    output seq_o_w, seq_valid_o, term_cnt_o, overflow_o, busy_o, done_o
  );

endinterface

`default_nettype wire

// File: rtl/seq_gen_multi_sum_tree.sv
// ============================================================================
// Module : seq_sum_tree
// Brief  : Combinational masked adder over the history window.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_sum_tree
  import seq_gen_pkg::*;
#(
  parameter int DataBus = 32,
  parameter int Depth   = 4
) (
  input  logic [Depth-1:0][DataBus-1:0] hist,
  input  logic [Depth-1:0]              mask,
  output logic [DataBus-1:0]            term,
  output logic                          ovf
);

  localparam int c_sum_w = sum_width(DataBus, Depth);

  logic [Depth-1:0][c_sum_w-1:0] w_tap;
  logic [c_sum_w-1:0]            w_sum;

  generate
    for (genvar k = 0; k < Depth; k++) begin : g_tap
      assign w_tap[k] = mask[k] ? {{(c_sum_w-DataBus){1'b0}}, hist[k]} : '0;
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < Depth; k++) begin
      w_sum = w_sum + w_tap[k];
    end
  end

  assign term = w_sum[DataBus-1:0];
  assign ovf  = |w_sum[c_sum_w-1:DataBus];

endmodule

`default_nettype wire

// File: rtl/seq_gen_multi.sv
// ============================================================================
// Module : seq_gen_multi
// Brief  : Masked linear-recurrence term generator with start/stop/limit
//          control and valid/ready output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_gen_multi
  import seq_gen_pkg::*;
#(
  parameter int               DataBus   = 32,
  parameter int               Depth     = 4,
  parameter int               CntW      = 16,
  parameter logic [Depth-1:0] ResetMask = Depth'(MASK_PADOVAN)
) (
  input  logic  clk_w,
  input  logic  reset_w,
  seq_gen_if.slave bus
);

  localparam logic [Depth*DataBus-1:0] c_hist_rst = (Depth*DataBus)'(1);

  state_t                        r_state;
  logic [Depth-1:0][DataBus-1:0] r_hist;
  logic [Depth-1:0]              r_mask;
  logic [DataBus-1:0]            r_seq;
  logic                          r_valid;
  logic [CntW-1:0]               r_cnt;
  logic                          r_ovf;
  logic [CntW-1:0]               r_limit;

  logic                          w_cfg_ok;
  logic [Depth-1:0][DataBus-1:0] w_hist_src;
  logic [Depth-1:0]              w_mask_src;
  logic [Depth-1:0][DataBus-1:0] w_hist_next;
  logic [DataBus-1:0]            w_term;
  logic                          w_ovf;
  logic                          w_out_free;
  logic                          w_limit_hit;
  logic [CntW-1:0]               w_cnt_base;
  logic                          w_ovf_base;

  // A load coinciding with start must feed the new seeds straight into the adder.
  assign w_cfg_ok    = bus.cfg_load_i && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_hist_src  = w_cfg_ok ? bus.cfg_seed_i : r_hist;
  assign w_mask_src  = w_cfg_ok ? bus.cfg_mask_i : r_mask;
  assign w_hist_next = {w_hist_src[Depth-2:0], w_term};
  assign w_out_free  = !r_valid || bus.seq_ready_i;
  assign w_limit_hit = (r_limit != '0) && (r_cnt == r_limit);
  assign w_cnt_base  = (w_cfg_ok || r_state == ST_DONE) ? '0 : r_cnt;
  assign w_ovf_base  = w_cfg_ok ? 1'b0 : r_ovf;

  seq_sum_tree #(
    .DataBus (DataBus),
    .Depth   (Depth)
  ) u_sum (
    .hist (w_hist_src),
    .mask (w_mask_src),
    .term (w_term),
    .ovf  (w_ovf)
  );

  always_ff @(posedge clk_w) begin
    if (reset_w) begin
      r_state <= ST_IDLE;
      r_hist  <= c_hist_rst;
      r_mask  <= ResetMask;
      r_seq   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_limit <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_cfg_ok) begin
            r_mask <= bus.cfg_mask_i;
            r_hist <= bus.cfg_seed_i;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
          end
          if (bus.start_i) begin
            r_limit <= bus.max_terms_i;
            r_seq   <= w_term;
            r_hist  <= w_hist_next;
            r_valid <= 1'b1;
            r_cnt   <= w_cnt_base + CntW'(1);
            r_ovf   <= w_ovf_base | w_ovf;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.stop_i) begin
            r_state <= ST_DRAIN;
          end else if (w_out_free) begin
            if (w_limit_hit) begin
              r_valid <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_seq   <= w_term;
              r_hist  <= w_hist_next;
              r_valid <= 1'b1;
              r_cnt   <= w_cnt_base + CntW'(1);
              r_ovf   <= w_ovf_base | w_ovf;
            end
          end
        end
        ST_DRAIN: begin
          if (w_out_free) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.seq_o_w     = r_seq;
  assign bus.seq_valid_o = r_valid;
  assign bus.term_cnt_o  = r_cnt;
  assign bus.overflow_o  = r_ovf;
  assign bus.busy_o      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign bus.done_o      = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_seq_gen_multi.sv
// ============================================================================
// Module : tb_seq_gen_multi
// Brief  : Scoreboard bench for seq_gen_multi (32-bit and 8-bit instances).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_seq_gen_multi;

  typedef struct packed {
    logic [31:0] term;
    logic        ovf;
  } exp_t;

  logic clk_w;
  logic rst_a;
  logic rst_b;
  int   n_checks;
  int   n_fail;
  int   n_wait;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a;
  exp_t e_b;

  seq_gen_if #(.DataBus(32), .Depth(4), .CntW(16)) bus_a ();
  seq_gen_if #(.DataBus(8),  .Depth(4), .CntW(16)) bus_b ();

  seq_gen_multi #(.DataBus(32), .Depth(4), .CntW(16)) u_dut_a (
    .clk_w   (clk_w),
    .reset_w (rst_a),
    .bus     (bus_a)
  );

  seq_gen_multi #(.DataBus(8), .Depth(4), .CntW(16)) u_dut_b (
    .clk_w   (clk_w),
    .reset_w (rst_b),
    .bus     (bus_b)
  );

  initial clk_w = 1'b0;
  always #5 clk_w = ~clk_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_w);
    #1;
  endtask

  task automatic push_a(input logic [31:0] t);
    q_a.push_back('{term: t, ovf: 1'b0});
  endtask

  task automatic wait_done_a(input int limit);
    n_wait = 0;
    while (!bus_a.done_o && n_wait < limit) begin
      tick();
      n_wait++;
    end
    check("a_done_reached", bus_a.done_o, 1);
  endtask

  // Transfers happen on the posedge following a negedge where valid && ready.
  always @(negedge clk_w) begin
    if (bus_a.seq_valid_o && bus_a.seq_ready_i) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected: got term %0d expected none", bus_a.seq_o_w);
      end else begin
        e_a = q_a.pop_front();
        check("a_term", bus_a.seq_o_w, e_a.term);
        check("a_ovf", bus_a.overflow_o, e_a.ovf);
      end
    end
  end

  always @(negedge clk_w) begin
    if (bus_b.seq_valid_o && bus_b.seq_ready_i) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected: got term %0d expected none", bus_b.seq_o_w);
      end else begin
        e_b = q_b.pop_front();
        check("b_term", bus_b.seq_o_w, e_b.term);
        check("b_ovf", bus_b.overflow_o, e_b.ovf);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pad[11] = '{0, 1, 1, 1, 2, 2, 3, 4, 5, 7, 9};
    int fib8[13] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121};
    n_checks = 0;
    n_fail   = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.cfg_load_i = 0; bus_a.cfg_mask_i = '0; bus_a.cfg_seed_i = '0;
    bus_a.start_i = 0; bus_a.stop_i = 0; bus_a.max_terms_i = '0; bus_a.seq_ready_i = 0;
    bus_b.cfg_load_i = 0; bus_b.cfg_mask_i = '0; bus_b.cfg_seed_i = '0;
    bus_b.start_i = 0; bus_b.stop_i = 0; bus_b.max_terms_i = '0; bus_b.seq_ready_i = 0;
    tick();
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;

    check("rst_seq",   bus_a.seq_o_w, 0);
    check("rst_valid", bus_a.seq_valid_o, 0);
    check("rst_cnt",   bus_a.term_cnt_o, 0);
    check("rst_ovf",   bus_a.overflow_o, 0);
    check("rst_busy",  bus_a.busy_o, 0);
    check("rst_done",  bus_a.done_o, 0);

    // Default Padovan, 11 terms at full rate
    foreach (pad[i]) push_a(pad[i]);
    bus_a.seq_ready_i = 1;
    bus_a.max_terms_i = 16'd11;
    bus_a.start_i = 1;
    tick();
    bus_a.start_i = 0;
    check("pad_first_valid", bus_a.seq_valid_o, 1);
    wait_done_a(40);
    check("pad_cycles", n_wait, 11);
    check("pad_valid_low", bus_a.seq_valid_o, 0);
    check("pad_cnt", bus_a.term_cnt_o, 11);
    check("pad_drained", q_a.size(), 0);

    // Fibonacci load and start in the same cycle from DONE
    foreach (fib8[i]) if (i < 6) push_a(fib8[i]);
    bus_a.cfg_load_i = 1;
    bus_a.cfg_mask_i = 4'b0011;
    bus_a.cfg_seed_i = 128'd1;
    bus_a.max_terms_i = 16'd6;
    bus_a.start_i = 1;
    tick();
    bus_a.cfg_load_i = 0;
    bus_a.start_i = 0;
    wait_done_a(40);
    check("fib_cnt", bus_a.term_cnt_o, 6);
    check("fib_drained", q_a.size(), 0);

    // Backpressure hold, then stop while a term is held
    bus_a.cfg_load_i = 1;
    tick();
    bus_a.cfg_load_i = 0;
    check("load_clears_cnt", bus_a.term_cnt_o, 0);
    push_a(1); push_a(2); push_a(3); push_a(5); push_a(8);
    bus_a.max_terms_i = '0;
    bus_a.start_i = 1;
    tick();
    bus_a.start_i = 0;
    check("hold_first", bus_a.seq_o_w, 1);
    tick();
    tick();
    check("hold_third", bus_a.seq_o_w, 3);
    bus_a.seq_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_seq", bus_a.seq_o_w, 3);
      check("hold_valid", bus_a.seq_valid_o, 1);
    end
    bus_a.seq_ready_i = 1;
    tick();
    check("after_accept", bus_a.seq_o_w, 5);
    bus_a.seq_ready_i = 0;
    bus_a.stop_i = 1;
    tick();
    bus_a.stop_i = 0;
    check("drain_busy", bus_a.busy_o, 1);
    check("drain_seq", bus_a.seq_o_w, 5);
    tick();
    check("drain_busy2", bus_a.busy_o, 1);
    bus_a.seq_ready_i = 1;
    tick();
    check("stop_idle", bus_a.busy_o, 0);
    check("stop_valid", bus_a.seq_valid_o, 0);
    check("stop_cnt", bus_a.term_cnt_o, 4);
    bus_a.start_i = 1;
    tick();
    bus_a.start_i = 0;
    check("resume_seq", bus_a.seq_o_w, 8);
    check("resume_cnt", bus_a.term_cnt_o, 5);
    bus_a.seq_ready_i = 0;
    bus_a.stop_i = 1;
    tick();
    bus_a.stop_i = 0;
    bus_a.seq_ready_i = 1;
    tick();
    check("stop2_idle", bus_a.busy_o, 0);
    check("stop2_drained", q_a.size(), 0);

    // Reset while a term is held
    bus_a.seq_ready_i = 0;
    bus_a.start_i = 1;
    tick();
    bus_a.start_i = 0;
    check("pre_rst_seq", bus_a.seq_o_w, 13);
    rst_a = 1;
    tick();
    rst_a = 0;
    check("mid_rst_seq",   bus_a.seq_o_w, 0);
    check("mid_rst_valid", bus_a.seq_valid_o, 0);
    check("mid_rst_cnt",   bus_a.term_cnt_o, 0);
    check("mid_rst_ovf",   bus_a.overflow_o, 0);
    check("mid_rst_busy",  bus_a.busy_o, 0);
    foreach (pad[i]) if (i < 5) push_a(pad[i]);
    bus_a.seq_ready_i = 1;
    bus_a.max_terms_i = 16'd5;
    bus_a.start_i = 1;
    tick();
    bus_a.start_i = 0;
    wait_done_a(40);
    check("post_rst_cnt", bus_a.term_cnt_o, 5);

    // 8-bit Fibonacci: wrap at term 13 sets sticky overflow
    bus_b.cfg_load_i = 1;
    bus_b.cfg_mask_i = 4'b0011;
    bus_b.cfg_seed_i = 32'd1;
    tick();
    bus_b.cfg_load_i = 0;
    foreach (fib8[i]) q_b.push_back('{term: fib8[i], ovf: (i == 12)});
    bus_b.seq_ready_i = 1;
    bus_b.start_i = 1;
    tick();
    bus_b.start_i = 0;
    repeat (12) tick();
    bus_b.seq_ready_i = 0;
    bus_b.stop_i = 1;
    tick();
    bus_b.stop_i = 0;
    bus_b.seq_ready_i = 1;
    tick();
    check("b_idle", bus_b.busy_o, 0);
    check("b_ovf_sticky", bus_b.overflow_o, 1);
    check("b_cnt", bus_b.term_cnt_o, 13);
    tick();
    check("b_ovf_sticky2", bus_b.overflow_o, 1);
    bus_b.cfg_load_i = 1;
    tick();
    bus_b.cfg_load_i = 0;
    check("b_ovf_cleared", bus_b.overflow_o, 0);
    check("b_drained", q_b.size(), 0);
    check("a_drained_final", q_a.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
